// File: rtl/func_sweep_pkg.sv
// func_sweep_pkg
// Shared types and constants for the func_sweep_ctrl self-test sequencer.
//   sweep_state_t    : controller state (IDLE, RUN, DONE)
//   NUM_VEC / IDX_W  : number of input vectors of the 4-input datapath and the
//                      width of the vector index
//   DEFAULT_EXPECTED : golden truth table of the 4-input XOR (bit k = y(k))
package func_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sweep_state_t;

    localparam int NUM_VEC = 16;
    localparam int IDX_W   = 4;

    localparam logic [15:0] DEFAULT_EXPECTED = 16'h6996;

endpackage

// File: rtl/func_sweep_ctrl_popcount16.sv
// popcount16
// Purely combinational population count of a 16-bit word.
//   vec : input  [15:0]  word to count
//   cnt : output [4:0]   number of ones in vec (0..16)
module popcount16 (
    input  logic [15:0] vec,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(vec[i]);
        end
    end

endmodule

// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl
// Built-in self-test sequencer for the 4-input combinational func datapath.
// On start it steps {a,b,c,d} through 0..15, waits SETTLE extra cycles per
// vector, samples y on the last cycle of each vector window and assembles the
// 16-bit truth table. Optional compare logic (macro FUNC_SWEEP_CHECK_EN)
// checks the table against EXPECTED; without the macro pass/mismatch_cnt
// are tied to 0.
// Parameters:
//   SETTLE   : idle cycles per vector before y is sampled (0..255)
//   EXPECTED : golden truth table, bit k = required y for vector k
// Ports:
//   clk          : clock, all logic on rising edge
//   rst          : synchronous active-high reset
//   start        : sweep request, honoured in IDLE only
//   a,b,c,d      : registered vector bits 3..0 (always equal to idx)
//   y            : func output under test
//   busy         : high while the sweep runs
//   done         : one-cycle pulse when the table is complete
//   table_out    : captured truth table, bit k = y under vector k
//   pass         : table_out == EXPECTED, valid from done
//   mismatch_cnt : popcount(table_out ^ EXPECTED), valid from done
module func_sweep_ctrl
    import func_sweep_pkg::*;
#(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = DEFAULT_EXPECTED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        pass,
    output logic [4:0]  mismatch_cnt
);

    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);

    sweep_state_t     state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             busy_next;
    logic             done_next;
    logic [15:0]      table_next;
    // Table including the bit being sampled this cycle; the final compare
    // uses it so that pass/mismatch_cnt are already valid alongside done.
    logic [15:0]      table_sampled;

    assign {a, b, c, d} = idx;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_next         = state;
        idx_next           = idx;
        cnt_next           = cnt;
        busy_next          = busy;
        done_next          = 1'b0;
        table_next         = table_out;
        table_sampled      = table_out;
        table_sampled[idx] = y;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    idx_next   = '0;
                    cnt_next   = SETTLE_LD;
                    busy_next  = 1'b1;
                    table_next = '0;
                end
            end
            RUN: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    table_next = table_sampled;
                    if (idx == LAST_IDX) begin
                        state_next = DONE;
                        idx_next   = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx + 1'b1;
                        cnt_next = SETTLE_LD;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
        end else begin
            idx       <= idx_next;
            cnt       <= cnt_next;
            busy      <= busy_next;
            done      <= done_next;
            table_out <= table_next;
        end
    end

`ifdef FUNC_SWEEP_CHECK_EN
    logic       clear_res;
    logic       final_load;
    logic [4:0] diff_cnt;

    assign clear_res  = (state == IDLE) && start;
    assign final_load = (state == RUN) && (cnt == '0) && (idx == LAST_IDX);

    popcount16 u_popcount16 (
        .vec (table_sampled ^ EXPECTED),
        .cnt (diff_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst || clear_res) begin
            pass         <= 1'b0;
            mismatch_cnt <= '0;
        end else if (final_load) begin
            pass         <= (table_sampled == EXPECTED);
            mismatch_cnt <= diff_cnt;
        end
    end
`else
    assign pass         = 1'b0;
    assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// tb_func_sweep_ctrl
// Directed self-checking bench for func_sweep_ctrl. Three instances:
//   u_x : SETTLE=1, y = a^b^c^d
//   u_a : SETTLE=0, y = a&b
//   u_s : SETTLE=3, y = a^b^c^d
// Cycle convention: the cycle in which start is sampled is T; after the
// accepting edge the bench stands in cycle T+1.
module tb_func_sweep_ctrl;

`ifdef FUNC_SWEEP_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic        start_x = 1'b0, xa, xb, xc, xd, y_x, busy_x, done_x, pass_x;
    logic [15:0] table_x;
    logic [4:0]  mm_x;
    logic        start_a = 1'b0, aa, ab, ac, ad, y_a, busy_a, done_a, pass_a;
    logic [15:0] table_a;
    logic [4:0]  mm_a;
    logic        start_s = 1'b0, sa, sb, sc, sd, y_s, busy_s, done_s, pass_s;
    logic [15:0] table_s;
    logic [4:0]  mm_s;

    assign y_x = xa ^ xb ^ xc ^ xd;
    assign y_a = aa & ab;
    assign y_s = sa ^ sb ^ sc ^ sd;

    func_sweep_ctrl #(.SETTLE(1)) u_x (
        .clk(clk), .rst(rst), .start(start_x), .a(xa), .b(xb), .c(xc), .d(xd),
        .y(y_x), .busy(busy_x), .done(done_x), .table_out(table_x),
        .pass(pass_x), .mismatch_cnt(mm_x)
    );

    func_sweep_ctrl #(.SETTLE(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .a(aa), .b(ab), .c(ac), .d(ad),
        .y(y_a), .busy(busy_a), .done(done_a), .table_out(table_a),
        .pass(pass_a), .mismatch_cnt(mm_a)
    );

    func_sweep_ctrl #(.SETTLE(3)) u_s (
        .clk(clk), .rst(rst), .start(start_s), .a(sa), .b(sb), .c(sc), .d(sd),
        .y(y_s), .busy(busy_s), .done(done_s), .table_out(table_s),
        .pass(pass_s), .mismatch_cnt(mm_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0:       return done_x;
            1:       return done_a;
            default: return done_s;
        endcase
    endfunction

    // Returns the cycle index (relative to T) at which done is seen, or 0 if
    // it does not appear within the budget.
    task automatic count_to_done(input int w, output int cyc);
        cyc = 1;
        while (!done_of(w) && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!done_of(w)) cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({xa, xb, xc, xd, busy_x, done_x, pass_x} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 0000000", {xa, xb, xc, xd, busy_x, done_x, pass_x});
        end
        checks++;
        if (table_x !== 16'h0000 || mm_x !== 5'd0) begin
            errors++;
            $display("FAIL reset_results: table=%h mm=%0d, want 0000/0", table_x, mm_x);
        end
        checks++;
        if (table_a !== 16'h0000 || table_s !== 16'h0000 || busy_a !== 1'b0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_others: table_a=%h table_s=%h busy_a=%b busy_s=%b, want 0", table_a, table_s, busy_a, busy_s);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_xor_sweep();
        int cyc;
        start_x = 1'b1;
        tick();
        start_x = 1'b0;
        checks++;
        if (busy_x !== 1'b1 || {xa, xb, xc, xd} !== 4'd0) begin
            errors++;
            $display("FAIL xor_first_cycle: busy=%b vec=%b, want 1/0000", busy_x, {xa, xb, xc, xd});
        end
        count_to_done(0, cyc);
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL xor_latency: done at T+%0d, want T+33", cyc);
        end
        checks++;
        if (table_x !== 16'h6996) begin
            errors++;
            $display("FAIL xor_table: got %h, want 6996", table_x);
        end
        checks++;
        if (pass_x !== CHECK_EN || mm_x !== 5'd0) begin
            errors++;
            $display("FAIL xor_compare: pass=%b mm=%0d, want %b/0", pass_x, mm_x, CHECK_EN);
        end
        checks++;
        if (busy_x !== 1'b0 || {xa, xb, xc, xd} !== 4'd0) begin
            errors++;
            $display("FAIL xor_done_state: busy=%b vec=%b, want 0/0000", busy_x, {xa, xb, xc, xd});
        end
        tick();
        tick();
        checks++;
        if (done_x !== 1'b0 || table_x !== 16'h6996 || pass_x !== CHECK_EN) begin
            errors++;
            $display("FAIL xor_hold: done=%b table=%h pass=%b, want 0/6996/%b", done_x, table_x, pass_x, CHECK_EN);
        end
    endtask

    task automatic test_and_sweep();
        int cyc;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        count_to_done(1, cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL and_latency: done at T+%0d, want T+17", cyc);
        end
        checks++;
        if (table_a !== 16'hF000) begin
            errors++;
            $display("FAIL and_table: got %h, want f000", table_a);
        end
        checks++;
        if (pass_a !== 1'b0 || mm_a !== (CHECK_EN ? 5'd8 : 5'd0)) begin
            errors++;
            $display("FAIL and_compare: pass=%b mm=%0d, want 0/%0d", pass_a, mm_a, CHECK_EN ? 8 : 0);
        end
        tick();
    endtask

    task automatic test_settle3();
        int bad_vec  = 0;
        int bad_busy = 0;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int t = 1; t <= 64; t++) begin
            if ({sa, sb, sc, sd} !== 4'((t - 1) / 4)) bad_vec++;
            if (busy_s !== 1'b1 || done_s !== 1'b0) bad_busy++;
            tick();
        end
        checks++;
        if (bad_vec != 0) begin
            errors++;
            $display("FAIL s3_vector_steps: %0d cycles with wrong vector, want 0", bad_vec);
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL s3_busy_window: %0d cycles with busy/done wrong, want 0", bad_busy);
        end
        checks++;
        if (done_s !== 1'b1 || busy_s !== 1'b0 || table_s !== 16'h6996) begin
            errors++;
            $display("FAIL s3_done_at_65: done=%b busy=%b table=%h, want 1/0/6996", done_s, busy_s, table_s);
        end
        tick();
        checks++;
        if (done_s !== 1'b0) begin
            errors++;
            $display("FAIL s3_done_pulse: done=%b at T+66, want 0", done_s);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_x = 1'b1;
        tick();
        count_to_done(0, cyc);
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL b2b_first_latency: done at T+%0d, want T+33", cyc);
        end
        tick();
        checks++;
        if (busy_x !== 1'b0 || done_x !== 1'b0 || table_x !== 16'h6996) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b table=%h, want 0/0/6996", busy_x, done_x, table_x);
        end
        tick();
        checks++;
        if (busy_x !== 1'b1 || table_x !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_reaccept: busy=%b table=%h, want 1/0000", busy_x, table_x);
        end
        count_to_done(0, cyc);
        start_x = 1'b0;
        checks++;
        if (cyc !== 33 || table_x !== 16'h6996) begin
            errors++;
            $display("FAIL b2b_second_done: done at T+%0d table=%h, want T+33/6996", cyc, table_x);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen_done = 0;
        start_x = 1'b1;
        tick();
        start_x = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if ({xa, xb, xc, xd} !== 4'd7 || busy_x !== 1'b1) begin
            errors++;
            $display("FAIL abort_at_vec7: vec=%b busy=%b, want 0111/1", {xa, xb, xc, xd}, busy_x);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({xa, xb, xc, xd, busy_x, done_x, pass_x} !== 7'b0 || table_x !== 16'h0 || mm_x !== 5'd0) begin
            errors++;
            $display("FAIL abort_outputs: ctrl=%b table=%h mm=%0d, want 0", {xa, xb, xc, xd, busy_x, done_x, pass_x}, table_x, mm_x);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_x === 1'b1 || busy_x === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d cycles with done/busy after abort, want 0", seen_done);
        end
        start_x = 1'b1;
        tick();
        start_x = 1'b0;
        count_to_done(0, cyc);
        checks++;
        if (cyc !== 33 || table_x !== 16'h6996 || pass_x !== CHECK_EN) begin
            errors++;
            $display("FAIL abort_fresh_sweep: done at T+%0d table=%h pass=%b, want T+33/6996/%b", cyc, table_x, pass_x, CHECK_EN);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_xor_sweep();
        test_and_sweep();
        test_settle3();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/func_sweep_ctrl.md
# func_sweep_ctrl

Sequencer that exhaustively exercises the 4-input combinational `func` datapath in hardware. On a start request it drives all 16 input vectors onto `a,b,c,d` in ascending order with `a` as MSB. After a programmable settle time it samples `y` for each vector and assembles a 16-bit truth table. An optional compare stage checks that table against a golden value. It sits beside `func` as its built-in self-test controller.

## Interface
- `SETTLE`, default 1: idle cycles per vector before `y` is sampled; legal range 0..255.
- `EXPECTED`, default 16'h6996: golden truth table, bit k = required `y` for vector k.

Ports:
- `clk` input 1: single clock, all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: sweep request, sampled in IDLE only.
- `a` output 1: vector bit 3, registered.
- `b` output 1: vector bit 2, registered.
- `c` output 1: vector bit 1, registered.
- `d` output 1: vector bit 0, registered.
- `y` input 1: `func` output, sampled.
- `busy` output 1: high while the sweep runs.
- `done` output 1: one-cycle pulse when the table is complete.
- `table_out` output 16: captured truth table; bit k = `y` under vector k.
- `pass` output 1: `table_out == EXPECTED`, valid from `done`.
- `mismatch_cnt` output 5: popcount of `table_out ^ EXPECTED`, valid from `done`.

## Operation
- States: IDLE, RUN, DONE.
- Reset sets state to IDLE and clears `idx`, `cnt`, `a..d`, `busy`, `done`, `table_out`, `pass` and `mismatch_cnt`.
- `{a,b,c,d}` always equals the 4-bit register `idx`.
- **IDLE:**
  - `start`=1 → RUN with `idx`=0, `cnt`=SETTLE, `busy`=1.
  - `table_out`, `pass` and `mismatch_cnt` are cleared on start acceptance.
- **RUN, each cycle:**
  - If `cnt`≠0, decrement `cnt`.
  - Otherwise set `table_out[idx]`←`y`.
  - Then, if `idx`=15, go to DONE. Otherwise increment `idx` and set `cnt`←SETTLE.
- **DONE:**
  - `done`=1 and `busy`=0 for exactly one cycle, with `idx` reset to 0.
  - `pass` and `mismatch_cnt` are registered from the final table.
  - Next state is IDLE.
- `start` is ignored in RUN and DONE; there is no queuing.
- Results hold until the next accepted `start` or `rst`.
- `rst` mid-sweep aborts immediately: outputs return to their reset values, and no `done` is produced.
- `idx` never wraps inside a sweep; the 15→0 transition happens only via DONE.

## Timing
- `start` sampled high at edge T → vector 0 on `a..d` and `busy`=1 from T+1.
- Vector k is applied from T+1+k·(SETTLE+1).
- Vector k is sampled on the last cycle of its window, so `func` has SETTLE+1 cycles of settle.
- Final sample is at T+16·(SETTLE+1).
- `done` and valid results are at T+16·(SETTLE+1)+1.
- A back-to-back `start` is accepted no earlier than the cycle after `done`.
- Total latency: 16·(SETTLE+1)+1 cycles from accept to `done`.

## Configuration
- `FUNC_SWEEP_CHECK_EN` defined: the compare logic is built. `pass` and `mismatch_cnt` behave as specified above.
- `FUNC_SWEEP_CHECK_EN` undefined: the compare logic and popcount are omitted, and `pass`/`mismatch_cnt` are tied to 0.
- The port list is identical in both builds.

## Structure
- Package `func_sweep_pkg` holds:
  - the state enum `sweep_state_t` (IDLE, RUN, DONE);
  - `NUM_VEC`=16 and `IDX_W`=4;
  - `DEFAULT_EXPECTED`=16'h6996.
- Sub-module `popcount16`: combinational 16→5 bit count, instantiated only under `FUNC_SWEEP_CHECK_EN`.
- `cnt` width is $clog2(SETTLE+1), minimum 1.

## Test plan
- XOR model (`y`=a^b^c^d), SETTLE=1, start at T → `done` at T+33, `table_out`=16'h6996, `pass`=1, `mismatch_cnt`=0.
- AND model (`y`=a&b), SETTLE=0, default EXPECTED → `done` at T+17, `table_out`=16'hF000, `pass`=0, `mismatch_cnt`=8.
- SETTLE=3 → each vector held 4 cycles with `a..d` stepping 0000,0001,…,1111. `busy` is high for 64 cycles, and `done` is a single-cycle pulse at T+65.
- `start` held high continuously → second sweep accepted at the cycle after `done`. `table_out` clears at acceptance, and the second `done` follows 16·(SETTLE+1)+1 cycles later.
- `rst` asserted at vector 7 → next cycle all outputs are 0 and state is IDLE. No `done` pulse appears, and a fresh `start` runs a full sweep.
- Build without `FUNC_SWEEP_CHECK_EN`, AND model → `table_out`=16'hF000 while `pass`=0 and `mismatch_cnt`=0.
